// File: rtl/wb_trap_commit.sv
// Writeback/commit stage: retires instructions into the register file and CSRs,
// steers the front end on jumps/MRET, and sequences machine-mode trap entry.
module wb_trap_commit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WB_V,
  output logic              WB_READY,
  input  logic [31:0]       WB_IR,
  input  logic [XLEN-1:0]   WB_PC,
  input  logic [XLEN-1:0]   WB_NPC,
  input  logic [XLEN-1:0]   WB_ALU_RESULT,
  input  logic [XLEN-1:0]   WB_MEM_RESULT,
  input  logic [XLEN-1:0]   WB_CSR_OLD,
  input  logic [XLEN-1:0]   WB_CSR_NEW,
  input  logic              WB_PC_MUX,
  input  logic              WB_EXC,
  input  logic [4:0]        WB_EXC_CODE,
  input  logic [XLEN-1:0]   WB_TVAL,
  input  logic [1:0]        IRQ_PEND,
  input  logic              IRQ_EN,
  input  logic [XLEN-1:0]   MTVEC,
  input  logic [XLEN-1:0]   MEPC,
  output logic              RF_WE,
  output logic [4:0]        RF_WADDR,
  output logic [XLEN-1:0]   RF_WDATA,
  output logic              CSR_WE,
  output logic [11:0]       CSR_ADDR,
  output logic [XLEN-1:0]   CSR_WDATA,
  output logic              REDIRECT,
  output logic [XLEN-1:0]   REDIRECT_PC,
  output logic              FLUSH,
  output logic [CNT_W-1:0]  INSTRET
);

  typedef enum logic [2:0] {IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, VECTOR} state_t;

  localparam logic [31:0] MRET_IR    = 32'h30200073;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              csr_we_q, csr_we_d;
  logic [11:0]       csr_addr_q, csr_addr_d;
  logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
  logic              redirect_q, redirect_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              flush_q, flush_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   tval_q, tval_d;

  logic              xfer;
  logic              irq_ext, irq_tmr, take_trap;
  logic              rf_hit, is_csr, is_mret;
  logic [XLEN-1:0]   rf_src;

  assign xfer      = WB_V & ready_q;
  assign irq_ext   = IRQ_EN & IRQ_PEND[1];
  assign irq_tmr   = IRQ_EN & IRQ_PEND[0];
  assign take_trap = irq_ext | irq_tmr | WB_EXC;
  assign is_mret   = (WB_IR == MRET_IR);

  // Result source by major opcode; SYSTEM with funct3==0 (ECALL/EBREAK/MRET) writes nothing.
  always_comb begin
    rf_hit = 1'b0;
    rf_src = '0;
    is_csr = 1'b0;
    case (WB_IR[6:0])
      7'b0000011: begin
        rf_hit = 1'b1;
        rf_src = WB_MEM_RESULT;
      end
      7'b0010011, 7'b0110011, 7'b0011011, 7'b0111011, 7'b0110111, 7'b0010111: begin
        rf_hit = 1'b1;
        rf_src = WB_ALU_RESULT;
      end
      7'b1101111, 7'b1100111: begin
        rf_hit = 1'b1;
        rf_src = WB_NPC;
      end
      7'b1110011: begin
        if (WB_IR[14:12] != 3'b000) begin
          rf_hit = 1'b1;
          rf_src = WB_CSR_OLD;
          is_csr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    ready_d       = ready_q;
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    csr_we_d      = 1'b0;
    csr_addr_d    = csr_addr_q;
    csr_wdata_d   = csr_wdata_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    flush_d       = 1'b0;
    instret_d     = instret_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    tval_d        = tval_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (xfer) begin
          if (take_trap) begin
            // The mepc write is issued straight from the transfer edge.
            epc_d   = WB_PC;
            cause_d = '0;
            if (irq_ext) begin
              cause_d[XLEN-1] = 1'b1;
              cause_d[4:0]    = 5'd11;
              tval_d          = '0;
            end else if (irq_tmr) begin
              cause_d[XLEN-1] = 1'b1;
              cause_d[4:0]    = 5'd7;
              tval_d          = '0;
            end else begin
              cause_d[4:0]    = WB_EXC_CODE;
              tval_d          = WB_TVAL;
            end
            csr_we_d    = 1'b1;
            csr_addr_d  = CSR_MEPC;
            csr_wdata_d = WB_PC;
            ready_d     = 1'b0;
            state_d     = SAVE_EPC;
          end else begin
            instret_d = instret_q + CNT_W'(1);
            if (rf_hit && (WB_IR[11:7] != 5'd0)) begin
              rf_we_d    = 1'b1;
              rf_waddr_d = WB_IR[11:7];
              rf_wdata_d = rf_src;
            end
            if (is_csr) begin
              csr_we_d    = 1'b1;
              csr_addr_d  = WB_IR[31:20];
              csr_wdata_d = WB_CSR_NEW;
            end
            if (is_mret) begin
              redirect_d    = 1'b1;
              redirect_pc_d = MEPC;
              flush_d       = 1'b1;
            end else if (WB_PC_MUX) begin
              redirect_d    = 1'b1;
              redirect_pc_d = WB_ALU_RESULT;
              flush_d       = 1'b1;
            end
          end
        end
      end
      SAVE_EPC: begin
        csr_we_d    = 1'b1;
        csr_addr_d  = CSR_MCAUSE;
        csr_wdata_d = cause_q;
        state_d     = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        csr_we_d    = 1'b1;
        csr_addr_d  = CSR_MTVAL;
        csr_wdata_d = tval_q;
        state_d     = SAVE_TVAL;
      end
      SAVE_TVAL: begin
        redirect_d    = 1'b1;
        redirect_pc_d = MTVEC;
        flush_d       = 1'b1;
        state_d       = VECTOR;
      end
      VECTOR: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      csr_we_q      <= 1'b0;
      csr_addr_q    <= '0;
      csr_wdata_q   <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      instret_q     <= '0;
      epc_q         <= '0;
      cause_q       <= '0;
      tval_q        <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      csr_we_q      <= csr_we_d;
      csr_addr_q    <= csr_addr_d;
      csr_wdata_q   <= csr_wdata_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      instret_q     <= instret_d;
      epc_q         <= epc_d;
      cause_q       <= cause_d;
      tval_q        <= tval_d;
    end
  end

  assign WB_READY    = ready_q;
  assign RF_WE       = rf_we_q;
  assign RF_WADDR    = rf_waddr_q;
  assign RF_WDATA    = rf_wdata_q;
  assign CSR_WE      = csr_we_q;
  assign CSR_ADDR    = csr_addr_q;
  assign CSR_WDATA   = csr_wdata_q;
  assign REDIRECT    = redirect_q;
  assign REDIRECT_PC = redirect_pc_q;
  assign FLUSH       = flush_q;
  assign INSTRET     = instret_q;

endmodule
